// File: rtl/argmax_hex_ctrl_if.sv
// rtl/argmax_hex_ctrl_if.sv - request/result bundle for the argmax hex controller
interface argmax_hex_ctrl_if #(
    parameter int WIDTH       = 8,
    parameter int NUM_CLASSES = 10
);
    logic                         start;
    logic [WIDTH*NUM_CLASSES-1:0] data;
    logic                         busy;
    logic                         done;
    logic [3:0]                   class_idx;
    logic                         tie;
    logic [6:0]                   hex;

    modport master (
        output start, data,
        input  busy, done, class_idx, tie, hex
    );

    modport slave (
        input  start, data,
        output busy, done, class_idx, tie, hex
    );
endinterface

// File: rtl/argmax_hex_ctrl.sv
// rtl/argmax_hex_ctrl.sv - time-multiplexed argmax over FFN scores with 7-segment result; ARGMAX_SIGNED_EN selects signed scores
module argmax_hex_ctrl #(
    parameter int WIDTH       = 8,
    parameter int NUM_CLASSES = 10
) (
    input  logic               clock,
    input  logic               reset,
    argmax_hex_ctrl_if.slave   bus
);
    localparam int IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shadow [NUM_CLASSES];
    logic [WIDTH-1:0] r_best;
    logic [3:0]       r_best_idx;
    logic             r_tie;
    logic [IW-1:0]    r_i;

    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_class_idx;
    logic             r_tie_out;
    logic [6:0]       r_hex;

    logic [WIDTH-1:0] w_elem;
    logic             w_gt;
    logic             w_eq;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a hex digit
    function automatic logic [6:0] f_hex(input logic [3:0] idx);
        logic [6:0] seg;
        case (idx)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // The single shared comparator: current element against the running best
    assign w_elem = r_shadow[r_i];
`ifdef ARGMAX_SIGNED_EN
    assign w_gt   = $signed(w_elem) > $signed(r_best);
`else
    assign w_gt   = w_elem > r_best;
`endif
    assign w_eq   = (w_elem == r_best);

    // Scan scheduler: capture, walk one element per cycle, publish result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_shadow[c] <= '0;
            end
            r_best      <= '0;
            r_best_idx  <= '0;
            r_tie       <= 1'b0;
            r_i         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_class_idx <= '0;
            r_tie_out   <= 1'b0;
            r_hex       <= 7'b1111111;
        end else begin
            // busy/done lag the state by one edge so they span SCAN..DONE exactly
            r_busy <= (r_state != S_IDLE);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            r_shadow[c] <= bus.data[c*WIDTH +: WIDTH];
                        end
                        r_best     <= bus.data[0 +: WIDTH];
                        r_best_idx <= '0;
                        r_tie      <= 1'b0;
                        r_i        <= IW'(1);
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_gt) begin
                        r_best     <= w_elem;
                        r_best_idx <= 4'(r_i);
                        r_tie      <= 1'b0;
                    end else if (w_eq) begin
                        r_tie      <= 1'b1;
                    end
                    if (r_i == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end
                S_DONE: begin
                    r_class_idx <= r_best_idx;
                    r_tie_out   <= r_tie;
                    r_hex       <= r_tie ? 7'b1110111 : f_hex(r_best_idx);
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.class_idx = r_class_idx;
    assign bus.tie       = r_tie_out;
    assign bus.hex       = r_hex;
endmodule

// File: doc/argmax_hex_ctrl.md
# argmax_hex_ctrl

Sequential classifier-result controller at the output of the feed-forward stage. On a `start` pulse it captures the packed vector of `NUM_CLASSES` FFN scores and walks it one element per cycle through a single shared comparator. It then registers the winning class index, a tie flag and the 7-segment code that drives the board display. It replaces a flat combinational argmax tree with a time-multiplexed scheduler, so one comparator serves all classes.

## Interface
- `WIDTH`, default `FFN_OUT_WIDTH`: bit width of one class score.
- `NUM_CLASSES`, default `NUM_CLASSES`: number of scores. Legal range is 2..16.
- `clock`  in  1: single clock for the block.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a scan. Sampled only in IDLE.
- `data`  in  WIDTH*NUM_CLASSES: packed scores. Class i occupies bits [i*WIDTH +: WIDTH].
- `busy`  out  1: high while in SCAN or DONE.
- `done`  out  1: one-cycle pulse when the result registers update.
- `class_idx`  out  4: winning class. On a tie, this is the lowest index among the maxima.
- `tie`  out  1: high when the maximum value occurs more than once.
- `hex`  out  7: active-low segments, ordered {g,f,e,d,c,b,a}.

## Operation
- Internal registers: shadow copy of `data`, `best`, `best_idx`, `tie_r`, scan counter `i`.
- State IDLE:
  - `start` = 1: capture `data` into the shadow, load `best`=element 0, `best_idx`=0, `tie_r`=0, `i`=1, then go to SCAN.
  - Otherwise: hold.
- State SCAN, one element per cycle:
  - element i > `best`: `best`=element i, `best_idx`=i, `tie_r`=0.
  - element i == `best`: `tie_r`=1.
  - element i < `best`: no change.
  - When `i` == NUM_CLASSES-1, go to DONE; otherwise `i`++.
- State DONE, one cycle:
  - Register `class_idx`=`best_idx`, `tie`=`tie_r`, and `hex`.
  - Assert `done`.
  - Return to IDLE.
- Hex encoding:
  - `tie` → 1110111 (underscore).
  - Otherwise decode `class_idx`:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000
    - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Changing `data` after capture has no effect on the scan in progress.
- `start` asserted while `busy` is ignored. It is not queued.
- Result outputs hold their last values until the next DONE.

## Timing
- Reset values: `busy`=0, `done`=0, `class_idx`=0, `tie`=0, `hex`=1111111 (blank). State returns to IDLE.
- Reset is asynchronous. Asserting it mid-scan aborts the scan immediately, and no `done` follows.
- Latency, with `start` sampled at edge k:
  - `busy` is high from edge k+1.
  - Result outputs change and `done` goes high at edge k+NUM_CLASSES.
  - `busy` and `done` drop at edge k+NUM_CLASSES+1.
- A new `start` is accepted at edge k+NUM_CLASSES+1 at the earliest. Back-to-back scans therefore start every NUM_CLASSES+1 cycles.
- Only one comparator exists. Element i is compared during SCAN cycle i.

## Configuration
- `ARGMAX_SIGNED_EN` defined: scores are two's complement, and the comparator and `best` are signed.
- `ARGMAX_SIGNED_EN` undefined: scores are unsigned.
- State sequence and latency are identical in both builds.

## Test plan
- All ten scores = 5, pulse `start` → `done` exactly 10 cycles later, `tie`=1, `class_idx`=0, `hex`=1110111.
- in0=10, others 5 → `tie`=0, `class_idx`=0, `hex`=1000000.
- in9=20, in3=20, others 1 → `tie`=1, `class_idx`=3, `hex`=1110111.
- in9=7, others 2 → `class_idx`=9, `hex`=0010000.
- Further scan from the previous result, in9=7, others 2:
  - After `start`, change in0 to the maximum value: result is still class 9.
  - Second `start` while `busy`: no extra `done`.
- Reset pulsed mid-scan → all outputs at reset values, `hex`=1111111, no `done`.
- With `ARGMAX_SIGNED_EN`: in0 = all ones (−1), others 0 → `tie`=1, `class_idx`=1.
- Without `ARGMAX_SIGNED_EN`, same stimulus → `tie`=0, `class_idx`=0.
